// File: rtl/add_sub_writeback_sink.sv
// Result sink for the add/sub unit: buffers completed results in a small FIFO,
// arbitrates for the shared writeback port and drives GPR/XER/CR0 writes plus
// the reservation-station tag release.

package add_sub_writeback_sink_pkg;
    // Condition/exception payload travelling with each add/sub result.
    typedef struct packed {
        logic [31:0] xer;
        logic        xer_valid;
        logic        cr0_valid;
    } cond_exception_t;
endpackage

module add_sub_writeback_sink
    import add_sub_writeback_sink_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [31:0]            result_in,
    input  cond_exception_t        cr0_xer_in,
    output logic                   wb_req,
    input  logic                   wb_grant,
    output logic                   gpr_we,
    output logic [4:0]             gpr_addr,
    output logic [31:0]            gpr_data,
    output logic                   xer_we,
    output logic [31:0]            xer_data,
    output logic                   cr0_we,
    output logic [3:0]             cr0_data,
    output logic                   rs_release_valid,
    output logic [RS_ID_WIDTH-1:0] rs_release_id
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [RS_ID_WIDTH-1:0] mem_id   [FIFO_DEPTH];
    logic [4:0]             mem_addr [FIFO_DEPTH];
    logic [31:0]            mem_data [FIFO_DEPTH];
    cond_exception_t        mem_cond [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic             push_c;
    logic             pop_c;
    logic [31:0]      head_data_c;
    cond_exception_t  head_cond_c;
    logic [3:0]       head_cr0_c;

    // in_ready/wb_req are registered copies of the occupancy, so no pop bypass.
    assign push_c = in_valid & in_ready;
    assign pop_c  = wb_req & wb_grant;

    assign head_data_c = mem_data[rd_ptr];
    assign head_cond_c = mem_cond[rd_ptr];

    // CR0 = {LT, GT, EQ, SO}; bit 31 here is the architectural MSB (bit 0).
    assign head_cr0_c = {head_data_c[31],
                         ~head_data_c[31] & (|head_data_c),
                         head_data_c == 32'd0,
                         head_cond_c.xer[31]};

    // Occupancy after this edge's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_id[wr_ptr]   <= rs_id_in;
            mem_addr[wr_ptr] <= result_reg_addr_in;
            mem_data[wr_ptr] <= result_in;
            mem_cond[wr_ptr] <= cr0_xer_in;
        end
    end

    // Pointers, count and handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            wb_req   <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            in_ready <= (count_nxt != DEPTH_CNT);
            wb_req   <= (count_nxt != '0);
        end
    end

    // Writeback stage: strobes pulse on pop, data/addr hold between pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpr_we           <= 1'b0;
            gpr_addr         <= '0;
            gpr_data         <= '0;
            xer_we           <= 1'b0;
            xer_data         <= '0;
            cr0_we           <= 1'b0;
            cr0_data         <= '0;
            rs_release_valid <= 1'b0;
            rs_release_id    <= '0;
        end else begin
            gpr_we           <= pop_c;
            xer_we           <= pop_c & head_cond_c.xer_valid;
            cr0_we           <= pop_c & head_cond_c.cr0_valid;
            rs_release_valid <= pop_c;
            if (pop_c) begin
                gpr_addr      <= mem_addr[rd_ptr];
                gpr_data      <= head_data_c;
                xer_data      <= head_cond_c.xer;
                cr0_data      <= head_cr0_c;
                rs_release_id <= mem_id[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_add_sub_writeback_sink.sv
// Bench for add_sub_writeback_sink: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.

module tb_add_sub_writeback_sink;
    import add_sub_writeback_sink_pkg::*;

    localparam int unsigned RSW   = 5;
    localparam int          DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [RSW-1:0]  rs_id_in = '0;
    logic [4:0]      result_reg_addr_in = '0;
    logic [31:0]     result_in = '0;
    cond_exception_t cr0_xer_in = '0;
    logic            wb_req;
    logic            wb_grant = 1'b0;
    logic            gpr_we;
    logic [4:0]      gpr_addr;
    logic [31:0]     gpr_data;
    logic            xer_we;
    logic [31:0]     xer_data;
    logic            cr0_we;
    logic [3:0]      cr0_data;
    logic            rs_release_valid;
    logic [RSW-1:0]  rs_release_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RSW-1:0] id;
        logic [4:0]     addr;
        logic [31:0]    data;
        logic [31:0]    xer;
        logic           xv;
        logic           cv;
    } exp_t;

    exp_t        q[$];
    logic [31:0] wlog[$];

    add_sub_writeback_sink #(.RS_ID_WIDTH(RSW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .rs_id_in           (rs_id_in),
        .result_reg_addr_in (result_reg_addr_in),
        .result_in          (result_in),
        .cr0_xer_in         (cr0_xer_in),
        .wb_req             (wb_req),
        .wb_grant           (wb_grant),
        .gpr_we             (gpr_we),
        .gpr_addr           (gpr_addr),
        .gpr_data           (gpr_data),
        .xer_we             (xer_we),
        .xer_data           (xer_data),
        .cr0_we             (cr0_we),
        .cr0_data           (cr0_data),
        .rs_release_valid   (rs_release_valid),
        .rs_release_id      (rs_release_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // CR0 from signed interpretation of the result; SO is architectural xer bit 0.
    function automatic logic [3:0] cr0_of(input logic [31:0] r, input logic [31:0] x);
        int s;
        s = $signed(r);
        return {s < 0, s > 0, s == 0, x[31]};
    endfunction

    // Reference model and per-cycle comparison.
    initial begin : cmp
        exp_t           e;
        exp_t           n;
        logic           push, pop;
        logic           x_gpr_we, x_xer_we, x_cr0_we, x_rel, x_in_ready, x_wb_req;
        logic [4:0]     x_addr;
        logic [31:0]    x_data, x_xer;
        logic [3:0]     x_cr0;
        logic [RSW-1:0] x_id;
        x_gpr_we = 0; x_xer_we = 0; x_cr0_we = 0; x_rel = 0; x_in_ready = 0; x_wb_req = 0;
        x_addr = 0; x_data = 0; x_xer = 0; x_cr0 = 0; x_id = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                q.delete();
                x_gpr_we = 0; x_xer_we = 0; x_cr0_we = 0; x_rel = 0;
                x_addr = 0; x_data = 0; x_xer = 0; x_cr0 = 0; x_id = 0;
                x_in_ready = 0; x_wb_req = 0;
            end else begin
                push = in_valid && (q.size() < DEPTH);
                pop  = wb_grant && (q.size() != 0);
                x_gpr_we = 0; x_xer_we = 0; x_cr0_we = 0; x_rel = 0;
                if (pop) begin
                    e = q.pop_front();
                    x_gpr_we = 1; x_rel = 1;
                    x_xer_we = e.xv; x_cr0_we = e.cv;
                    x_addr = e.addr; x_data = e.data; x_xer = e.xer;
                    x_cr0 = cr0_of(e.data, e.xer); x_id = e.id;
                end
                if (push) begin
                    n.id = rs_id_in; n.addr = result_reg_addr_in; n.data = result_in;
                    n.xer = cr0_xer_in.xer; n.xv = cr0_xer_in.xer_valid; n.cv = cr0_xer_in.cr0_valid;
                    q.push_back(n);
                end
                x_in_ready = q.size() < DEPTH;
                x_wb_req   = q.size() != 0;
            end
            #1;
            check("m_in_ready", 32'(in_ready), 32'(x_in_ready));
            check("m_wb_req",   32'(wb_req),   32'(x_wb_req));
            check("m_gpr_we",   32'(gpr_we),   32'(x_gpr_we));
            check("m_gpr_addr", 32'(gpr_addr), 32'(x_addr));
            check("m_gpr_data", gpr_data,      x_data);
            check("m_xer_we",   32'(xer_we),   32'(x_xer_we));
            check("m_xer_data", xer_data,      x_xer);
            check("m_cr0_we",   32'(cr0_we),   32'(x_cr0_we));
            check("m_cr0_data", 32'(cr0_data), 32'(x_cr0));
            check("m_rel_v",    32'(rs_release_valid), 32'(x_rel));
            check("m_rel_id",   32'(rs_release_id),    32'(x_id));
            if (gpr_we) wlog.push_back(gpr_data);
        end
    end

    // Present one result from a negedge and hold it until accepted.
    task automatic send(input logic [4:0] id, input logic [4:0] addr, input logic [31:0] data,
                        input logic [31:0] xer, input logic xv, input logic cv, input bit rnd);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        rs_id_in = id;
        result_reg_addr_in = addr;
        result_in = data;
        cr0_xer_in.xer = xer;
        cr0_xer_in.xer_valid = xv;
        cr0_xer_in.cr0_valid = cv;
        for (int k = 0; k < 100 && !acc; k++) begin
            if (rnd) wb_grant = 1'($urandom_range(0, 1));
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("send_accept", 32'(acc), 32'd1);
    endtask

    // Grant until empty, bounded.
    task automatic drain();
        wb_grant = 1'b1;
        for (int k = 0; k < 40 && wb_req; k++) @(negedge clk);
        check("drain_empty", 32'(wb_req), 32'd0);
    endtask

    initial begin : stim
        // Power-on reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wb_req",   32'(wb_req),   32'd0);
        check("rst_gpr_we",   32'(gpr_we),   32'd0);
        check("rst_gpr_data", gpr_data,      32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Single op, grant held
        wb_grant = 1'b1;
        send(5'd3, 5'd7, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("single_gpr_we",  32'(gpr_we),   32'd1);
        check("single_addr",    32'(gpr_addr), 32'd7);
        check("single_cr0",     32'(cr0_data), 32'b0011);
        check("single_xer_we",  32'(xer_we),   32'd1);
        check("single_xer",     xer_data,      32'h8000_0000);
        check("single_rel_v",   32'(rs_release_valid), 32'd1);
        check("single_rel_id",  32'(rs_release_id),    32'd3);
        @(negedge clk);
        check("single_pulse_end", 32'(gpr_we), 32'd0);

        // CR0 signs
        send(5'd4, 5'd1, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("neg_cr0",    32'(cr0_data[3:1]), 32'b100);
        check("neg_cr0_we", 32'(cr0_we), 32'd1);
        check("neg_xer_we", 32'(xer_we), 32'd0);
        send(5'd5, 5'd2, 32'h0000_0005, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("pos_cr0",    32'(cr0_data), 32'b0101);
        send(5'd6, 5'd3, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("nocr0_we",   32'(cr0_we), 32'd0);
        check("nocr0_gpr",  32'(gpr_we), 32'd1);

        // Fill with grant low; 5th held off until a single grant frees a slot
        wb_grant = 1'b0;
        @(negedge clk);
        wlog.delete();
        for (int i = 0; i < 4; i++)
            send(5'(10 + i), 5'(i), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0);
        check("full_not_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        rs_id_in = 5'd14; result_reg_addr_in = 5'd4; result_in = 32'h104;
        cr0_xer_in = '0;
        repeat (3) begin
            @(negedge clk);
            check("full_held", 32'(in_ready), 32'd0);
        end
        wb_grant = 1'b1;
        @(negedge clk);
        wb_grant = 1'b0;
        check("freed_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("refull_ready", 32'(in_ready), 32'd0);
        drain();
        @(negedge clk);
        check("fill_count", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check("fill_order", wlog[i], 32'h100 + 32'(i));

        // Wrap/order with random grants
        wlog.delete();
        for (int i = 0; i < 10; i++)
            send(5'(i), 5'(i), 32'(i + 1), 32'h0, 1'b0, 1'b1, 1'b1);
        drain();
        @(negedge clk);
        check("wrap_count", 32'(wlog.size()), 32'd10);
        for (int i = 0; i < 10 && i < wlog.size(); i++)
            check("wrap_order", wlog[i], 32'(i + 1));

        // Full, then streaming push+pop with grant held
        wb_grant = 1'b0;
        wlog.delete();
        for (int i = 0; i < 4; i++)
            send(5'(20 + i), 5'(i), 32'h500 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0);
        wb_grant = 1'b1;
        for (int i = 4; i < 8; i++) begin
            send(5'(20 + i), 5'(i), 32'h500 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0);
            check("stream_ready", 32'(in_ready), 32'd1);
            check("stream_req",   32'(wb_req),   32'd1);
        end
        drain();
        @(negedge clk);
        check("stream_count", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            check("stream_order", wlog[i], 32'h500 + 32'(i));

        // Mid-stream reset with 3 entries buffered
        wb_grant = 1'b0;
        for (int i = 0; i < 3; i++)
            send(5'(i), 5'(i), 32'h900 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_req", 32'(wb_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_req",   32'(wb_req),   32'd0);
        @(negedge clk);
        wb_grant = 1'b1;
        @(negedge clk);
        check("mid_rst_gpr_we", 32'(gpr_we), 32'd0);
        check("mid_rst_ready2", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready",  32'(in_ready), 32'd1);
        check("rel_req",    32'(wb_req),   32'd0);
        check("rel_wr_ptr", 32'(dut.wr_ptr), 32'd0);
        send(5'd9, 5'd9, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_gpr_we", 32'(gpr_we),   32'd1);
        check("post_rst_data",   gpr_data,      32'h0000_ABCD);
        check("post_rst_id",     32'(rs_release_id), 32'd9);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
